// File: rtl/vga_pixel_timing_if.sv
// Scan and sync bundle between the pixel-timing generator (master) and the
// raytracer / pin drivers (slave).
interface vga_pixel_timing_if;
  // There is no valid/ready backpressure. The slave drives enable to let the
  // scan advance. pixel_x/pixel_y are meaningful on every clk, and
  // pixel_valid marks the visible region. pix_ce marks the single clk after
  // which the scan position steps. The *_out syncs and de are retimed copies
  // intended for the pins.
  logic        enable;
  logic        pix_ce;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  enable,
    output pix_ce, pixel_x, pixel_y, pixel_valid,
    output hsync_out, vsync_out, de_out, frame_start, frame_count
  );

  modport slave (
    output enable,
    input  pix_ce, pixel_x, pixel_y, pixel_valid,
    input  hsync_out, vsync_out, de_out, frame_start, frame_count
  );
endinterface

// File: rtl/vga_pixel_timing.sv
// VGA pixel-timing generator: clock divider, h/v scan counters, frame events
// and a programmable delay line that retimes hsync/vsync/de to the RGB path.
module vga_pixel_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_pixel_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word layout is {hsync, vsync, de}; idle value is syncs high, de low.
  localparam logic [2:0] DLY_IDLE = 3'b110;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             frame_start_q, frame_start_d;

  logic             pix_ce;
  logic             h_wrap;
  logic             v_wrap;
  logic             pixel_valid;
  logic             hs_raw;
  logic             vs_raw;
  logic [2:0]       raw_word;
  logic [2:0]       dly_out;

  assign pix_ce      = bus.enable && (div_q == DIV_LAST);
  assign h_wrap      = (h_q == H_LAST);
  assign v_wrap      = (v_q == V_LAST);
  assign pixel_valid = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hs_raw      = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw      = !((v_q >= VS_START) && (v_q < VS_END));
  assign raw_word    = {hs_raw, vs_raw, pixel_valid};

  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    frame_count_d = frame_count_q;
    frame_start_d = 1'b0;

    // The divider holds its phase while disabled so a stall resumes mid-pixel.
    if (bus.enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (pix_ce) begin
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_count_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_count_q <= frame_count_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The delay line free-runs on clk so it tracks the registered RGB path,
  // which is not gated by pix_ce or enable either.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign dly_out = raw_word;
  end else begin : g_delay
    logic [2:0] dly_q [SYNC_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          dly_q[i] <= DLY_IDLE;
        end
      end else begin
        dly_q[0] <= raw_word;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign dly_out = dly_q[SYNC_DELAY-1];
  end

  assign bus.pix_ce      = pix_ce;
  assign bus.pixel_x     = h_q;
  assign bus.pixel_y     = v_q;
  assign bus.pixel_valid = pixel_valid;
  assign bus.hsync_out   = dly_out[2];
  assign bus.vsync_out   = dly_out[1];
  assign bus.de_out      = dly_out[0];
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Bench for vga_pixel_timing on a reduced 15x8 raster: directed vector table,
// per-cycle formula checks over a frame, enable stall and async reset sequences.
module tb_vga_pixel_timing;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 8

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_pixel_timing_if if_a ();
  vga_pixel_timing_if if_d0 ();
  vga_pixel_timing_if if_d3 ();
  vga_pixel_timing_if if_e ();

  assign if_a.enable  = enable;
  assign if_d0.enable = enable;
  assign if_d3.enable = enable;
  assign if_e.enable  = enable;

  vga_pixel_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2), .SYNC_DELAY(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  vga_pixel_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2), .SYNC_DELAY(0))
    u_d0 (.clk(clk), .rst_n(rst_n), .bus(if_d0));
  vga_pixel_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2), .SYNC_DELAY(3))
    u_d3 (.clk(clk), .rst_n(rst_n), .bus(if_d3));
  vga_pixel_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1), .SYNC_DELAY(1))
    u_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

  typedef struct {
    int cyc; int x; int y; int ce; int val; int hs; int vs; int de; int fs; int fc;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int cyc, input int x, input int y, input int ce,
                         input int val, input int hs, input int vs, input int de,
                         input int fs, input int fc);
    vec_t v;
    v.cyc = cyc; v.x = x; v.y = y; v.ce = ce; v.val = val;
    v.hs = hs; v.vs = vs; v.de = de; v.fs = fs; v.fc = fc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int t, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Scan position of a CLK_DIV=2 instance t cycles after reset release, no stalls.
  function automatic int a_x(input int t);
    return (t / 2) % HT;
  endfunction
  function automatic int a_y(input int t);
    return ((t / 2) / HT) % VT;
  endfunction
  function automatic int a_valid(input int t);
    if (t < 0) return 0;
    return int'(a_x(t) < HA && a_y(t) < VA);
  endfunction
  function automatic int a_hs(input int t);
    if (t < 0) return 1;
    return int'(!(a_x(t) >= HA + HF && a_x(t) < HA + HF + HS));
  endfunction
  function automatic int a_vs(input int t);
    if (t < 0) return 1;
    return int'(!(a_y(t) >= VA + VF && a_y(t) < VA + VF + VS));
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"},     -1, int'(if_a.pixel_x), 0);
    chk({tag, "_y"},     -1, int'(if_a.pixel_y), 0);
    chk({tag, "_valid"}, -1, int'(if_a.pixel_valid), 1);
    chk({tag, "_hs"},    -1, int'(if_a.hsync_out), 1);
    chk({tag, "_vs"},    -1, int'(if_a.vsync_out), 1);
    chk({tag, "_de"},    -1, int'(if_a.de_out), 0);
    chk({tag, "_fs"},    -1, int'(if_a.frame_start), 0);
    chk({tag, "_fc"},    -1, int'(if_a.frame_count), 0);
    chk({tag, "_ce"},    -1, int'(if_a.pix_ce), 0);
    chk({tag, "_d3_de"}, -1, int'(if_d3.de_out), 0);
    chk({tag, "_e_fc"},  -1, int'(if_e.frame_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int found;
    int line_len;
    int de_cnt, hs_low, vs_low;

    //       cyc   x  y ce val hs vs de fs fc
    add_vec(  0,   0, 0, 0, 1, 1, 1, 0, 0, 0);
    add_vec(  1,   0, 0, 1, 1, 1, 1, 1, 0, 0);
    add_vec(  2,   1, 0, 0, 1, 1, 1, 1, 0, 0);
    add_vec(  3,   1, 0, 1, 1, 1, 1, 1, 0, 0);
    add_vec(  4,   2, 0, 0, 1, 1, 1, 1, 0, 0);
    add_vec( 16,   8, 0, 0, 0, 1, 1, 1, 0, 0);
    add_vec( 17,   8, 0, 1, 0, 1, 1, 0, 0, 0);
    add_vec( 20,  10, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec( 21,  10, 0, 1, 0, 0, 1, 0, 0, 0);
    add_vec( 26,  13, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec( 27,  13, 0, 1, 0, 1, 1, 0, 0, 0);
    add_vec( 29,  14, 0, 1, 0, 1, 1, 0, 0, 0);
    add_vec( 30,   0, 1, 0, 1, 1, 1, 0, 0, 0);
    add_vec( 31,   0, 1, 1, 1, 1, 1, 1, 0, 0);
    add_vec(150,   0, 5, 0, 0, 1, 1, 0, 0, 0);
    add_vec(151,   0, 5, 1, 0, 1, 0, 0, 0, 0);
    add_vec(210,   0, 7, 0, 0, 1, 0, 0, 0, 0);
    add_vec(211,   0, 7, 1, 0, 1, 1, 0, 0, 0);
    add_vec(239,  14, 7, 1, 0, 1, 1, 0, 0, 0);
    add_vec(240,   0, 0, 0, 1, 1, 1, 0, 1, 1);
    add_vec(241,   0, 0, 1, 1, 1, 1, 1, 0, 1);

    // Reset held
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    chk_reset_state("rst_hold");

    // Release with enable high; cycle 0 is sampled in the same half period.
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    #1;
    idx = 0;
    for (int t = 0; t <= 241; t++) begin
      if (t > 0) step();
      if (t == 1) chk("e_first_ce", t, int'(if_e.pix_ce), 1);
      if (idx < vecs.size() && vecs[idx].cyc == t) begin
        chk("vec_x",     t, int'(if_a.pixel_x),     vecs[idx].x);
        chk("vec_y",     t, int'(if_a.pixel_y),     vecs[idx].y);
        chk("vec_ce",    t, int'(if_a.pix_ce),      vecs[idx].ce);
        chk("vec_valid", t, int'(if_a.pixel_valid), vecs[idx].val);
        chk("vec_hs",    t, int'(if_a.hsync_out),   vecs[idx].hs);
        chk("vec_vs",    t, int'(if_a.vsync_out),   vecs[idx].vs);
        chk("vec_de",    t, int'(if_a.de_out),      vecs[idx].de);
        chk("vec_fs",    t, int'(if_a.frame_start), vecs[idx].fs);
        chk("vec_fc",    t, int'(if_a.frame_count), vecs[idx].fc);
        idx++;
      end
    end
    chk("vec_all_applied", -1, idx, vecs.size());

    // One full frame: per-cycle formulas, delay shifts of 0/1/3, sync/de totals.
    de_cnt = 0; hs_low = 0; vs_low = 0;
    for (int t = 242; t <= 481; t++) begin
      step();
      chk("a_x",     t, int'(if_a.pixel_x), a_x(t));
      chk("a_y",     t, int'(if_a.pixel_y), a_y(t));
      chk("a_ce",    t, int'(if_a.pix_ce), int'(t % 2 == 1));
      chk("a_fc",    t, int'(if_a.frame_count), t / 240);
      chk("a_fs",    t, int'(if_a.frame_start), int'(t % 240 == 0));
      chk("d0_de",   t, int'(if_d0.de_out), a_valid(t));
      chk("d0_vs",   t, int'(if_d0.vsync_out), a_vs(t));
      chk("d1_de",   t, int'(if_a.de_out), a_valid(t - 1));
      chk("d1_hs",   t, int'(if_a.hsync_out), a_hs(t - 1));
      chk("d3_de",   t, int'(if_d3.de_out), a_valid(t - 3));
      chk("d3_hs",   t, int'(if_d3.hsync_out), a_hs(t - 3));
      chk("e_x",     t, int'(if_e.pixel_x), t % HT);
      chk("e_y",     t, int'(if_e.pixel_y), (t / HT) % VT);
      chk("e_fc",    t, int'(if_e.frame_count), t / 120);
      chk("e_fs",    t, int'(if_e.frame_start), int'(t % 120 == 0));
      if (if_a.de_out)     de_cnt++;
      if (!if_a.hsync_out) hs_low++;
      if (!if_a.vsync_out) vs_low++;
    end
    chk("frame_de_clks",  -1, de_cnt, HA * VA * 2);
    chk("frame_hs_low",   -1, hs_low, HS * 2 * VT);
    chk("frame_vs_low",   -1, vs_low, VS * HT * 2);

    // Enable stall mid-pixel at x=5 for 37 clk.
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (if_a.pixel_x == 10'd0 && !if_a.pix_ce) found = 1;
    end
    chk("stall_find_line", -1, found, 1);
    line_len = 1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      line_len++;
      if (if_a.pixel_x == 10'd5 && if_a.pix_ce) found = 1;
    end
    chk("stall_find_x5", -1, found, 1);
    enable = 1'b0;
    #1;
    for (int i = 0; i < 37; i++) begin
      if (i > 0) begin
        step();
        line_len++;
      end
      chk("stall_x",  i, int'(if_a.pixel_x), 5);
      chk("stall_ce", i, int'(if_a.pix_ce), 0);
    end
    step();
    line_len++;
    enable = 1'b1;
    #1;
    chk("resume_ce", -1, int'(if_a.pix_ce), 1);
    chk("resume_x",  -1, int'(if_a.pixel_x), 5);
    step();
    line_len++;
    chk("resume_x6", -1, int'(if_a.pixel_x), 6);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (if_a.pixel_x == 10'd0 && !if_a.pix_ce) found = 1;
      else line_len++;
    end
    chk("stall_line_end", -1, found, 1);
    chk("stall_line_len", -1, line_len, HT * 2 + 37);

    // Asynchronous reset between edges in the visible region.
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      step();
      if (if_a.pixel_y == 10'd2 && if_a.pixel_x == 10'd3) found = 1;
    end
    chk("arst_find_pos", -1, found, 1);
    chk("arst_pre_de",   -1, int'(if_a.de_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_x0",  0, int'(if_a.pixel_x), 0);
    chk("arst_rel_ce0", 0, int'(if_a.pix_ce), 0);
    step();
    chk("arst_rel_ce1", 1, int'(if_a.pix_ce), 1);
    chk("arst_rel_x1",  1, int'(if_a.pixel_x), 0);
    step();
    chk("arst_rel_x2",  2, int'(if_a.pixel_x), 1);
    chk("arst_rel_fc",  2, int'(if_a.frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
